// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-cycle-latency 32-bit word RAM.
// Sub-word stores are done as read-modify-write; illegal requests are answered with an error only.
`ifndef ROM_COL_MAX
`define ROM_COL_MAX 64
`endif

module load_store_unit #(
   parameter int DEPTH = `ROM_COL_MAX
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] ram_addr,
   output logic        memread,
   output logic        memwrite,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;
   logic        r_memread;
   logic        r_memwrite;
   logic [31:0] r_ram_addr;
   logic [31:0] r_write_data;
   logic        r_write;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;

   logic        w_accept;
   logic        w_range_err;
   logic        w_req_err;

   // Lane select from a little-endian word, then zero/sign extension to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [31:0] lane;
      logic [31:0] res;
      lane = word >> {off, 3'b000};
      case (size)
         2'b00:   res = uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'b01:   res = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace only the addressed byte/half lane of the old word with the store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
      logic [31:0] res;
      res = word;
      case (size)
         2'b00:   res[{off, 3'b000} +: 8]        = wdata[7:0];
         2'b01:   res[{off[1], 4'b0000} +: 16]   = wdata[15:0];
         default: res = wdata;
      endcase
      return res;
   endfunction

   // Request legality, evaluated on the raw request so the error is known at acceptance.
   always_comb begin
      w_accept    = (r_state == IDLE) && req_valid;
      w_range_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
      w_req_err   = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                    w_range_err;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (w_req_err) begin
                  w_state_nxt = RESP;
               end else if (req_write && (req_size == 2'b10)) begin
                  w_state_nxt = WR;
               end else begin
                  w_state_nxt = RD;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RD:      w_state_nxt = WAIT;
         WAIT:    w_state_nxt = r_write ? WR : RESP;
         WR:      w_state_nxt = RESP;
         RESP:    w_state_nxt = rsp_ready ? IDLE : RESP;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Strobes are registered from the next state so they line up exactly with RD/WR/RESP.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_memread    <= 1'b0;
         r_memwrite   <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_rdata  <= 32'd0;
         r_ram_addr   <= 32'd0;
         r_write_data <= 32'd0;
         r_write      <= 1'b0;
         r_off        <= 2'b00;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
      end else begin
         r_req_ready <= (w_state_nxt == IDLE);
         r_rsp_valid <= (w_state_nxt == RESP);
         r_memread   <= (w_state_nxt == RD);
         r_memwrite  <= (w_state_nxt == WR);
         if (w_accept) begin
            r_write      <= req_write;
            r_off        <= req_addr[1:0];
            r_size       <= req_size;
            r_unsigned   <= req_unsigned;
            r_ram_addr   <= {2'b00, req_addr[31:2]};
            r_write_data <= req_wdata;
            r_rsp_rdata  <= 32'd0;
            r_rsp_err    <= w_req_err;
         end else if (r_state == WAIT) begin
            if (r_write) begin
               r_write_data <= store_merge(read_data, r_write_data, r_off, r_size);
            end else begin
               r_rsp_rdata  <= load_extend(read_data, r_off, r_size, r_unsigned);
            end
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_err    = r_rsp_err;
   assign rsp_rdata  = r_rsp_rdata;
   assign memread    = r_memread;
   assign memwrite   = r_memwrite;
   assign ram_addr   = r_ram_addr;
   assign write_data = r_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-WAIT sequence and random
// traffic checked against a byte-lane memory model with a simple word RAM attached.
module tb_load_store_unit;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic        CLK;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] ram_addr;
   logic        memread;
   logic        memwrite;
   logic [31:0] write_data;
   logic [31:0] read_data;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   int          total;
   int          bad;
   int          rd_cnt;
   int          wr_cnt;
   int          both_cnt;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          hold;
   } vec_t;

   vec_t vecs [16];

   load_store_unit #(.DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_addr     (ram_addr),
      .memread      (memread),
      .memwrite     (memwrite),
      .write_data   (write_data),
      .read_data    (read_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Attached RAM: data appears on read_data after the edge that saw memread.
   always @(posedge CLK) begin
      if (memwrite && (ram_addr < DEPTH)) mem[ram_addr[AW-1:0]] <= write_data;
      if (memread && (ram_addr < DEPTH)) read_data <= mem[ram_addr[AW-1:0]];
   end

   always @(negedge CLK) begin
      if (memread) rd_cnt = rd_cnt + 1;
      if (memwrite) begin
         wr_cnt     = wr_cnt + 1;
         last_waddr = ram_addr;
         last_wdata = write_data;
      end
      if (memread && memwrite) both_cnt = both_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%b expected=%b", name, act, exp);
      end
   endtask

   // Reference: memory as byte lanes, results from mask/shift arithmetic.
   task automatic model(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int          nbytes;
      int          sh;
      logic [31:0] mask;
      logic [31:0] v;
      logic [31:0] idx;
      idx = a >> 2;
      er  = (sz == 2'd3) || ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0)) || (idx >= DEPTH);
      rd  = 32'd0;
      if (!er) begin
         nbytes = 1 << sz;
         sh     = 8 * int'(a[1:0]);
         mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
         if (w) begin
            ref_mem[idx[AW-1:0]] = (ref_mem[idx[AW-1:0]] & ~(mask << sh)) | ((wd & mask) << sh);
         end else begin
            v = (ref_mem[idx[AW-1:0]] >> sh) & mask;
            if (!u && v[8*nbytes-1]) v = v | ~mask;
            rd = v;
         end
      end
   endtask

   task automatic run_req(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input int hold);
      int          lat;
      int          rd0;
      int          wr0;
      int          exp_lat;
      int          exp_rdc;
      int          exp_wrc;
      logic [31:0] idx;
      idx     = a >> 2;
      exp_lat = exp_err ? 1 : (!w ? 3 : ((sz == 2'd2) ? 2 : 4));
      exp_rdc = (exp_err || (w && (sz == 2'd2))) ? 0 : 1;
      exp_wrc = (!exp_err && w) ? 1 : 0;
      @(negedge CLK);
      chk_bit("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
      req_unsigned = u; req_wdata = wd;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge CLK); #1;
      // scramble request fields so any un-latched use shows up
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
      req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         rsp_ready = 1'($urandom_range(0, 1));
         @(posedge CLK); #1;
         lat++;
      end
      rsp_ready = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk_bit("rsp_err", rsp_err, exp_err);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         chk_bit("hold_valid", rsp_valid, 1'b1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk_bit("hold_err", rsp_err, exp_err);
         chk_bit("hold_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      chk_bit("resp_exit_valid", rsp_valid, 1'b0);
      chk_bit("resp_exit_ready", req_ready, 1'b1);
      chk("memread_count", 32'(rd_cnt - rd0), 32'(exp_rdc));
      chk("memwrite_count", 32'(wr_cnt - wr0), 32'(exp_wrc));
      chk("rd_wr_overlap", 32'(both_cnt), 32'd0);
      if (exp_wrc == 1) begin
         chk("write_addr", last_waddr, idx);
         chk("write_data", last_wdata, ref_mem[idx[AW-1:0]]);
         chk("ram_word", mem[idx[AW-1:0]], ref_mem[idx[AW-1:0]]);
      end
   endtask

   initial begin
      logic [31:0] m_rd;
      logic        m_err;
      logic        w;
      logic [31:0] a;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] wd;
      int          rd0;
      int          wr0;

      total = 0; bad = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      last_waddr = 32'd0; last_wdata = 32'd0; read_data = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 2'd0;
      req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;

      vecs[0]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 0};
      vecs[1]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 5};
      vecs[2]  = '{1'b1, 32'h12, 2'd0, 1'b0, 32'h0000005A, 32'h0,        1'b0, 0};
      vecs[3]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDE5ABEEF, 1'b0, 0};
      vecs[4]  = '{1'b1, 32'h20, 2'd2, 1'b0, 32'h80FF7F01, 32'h0,        1'b0, 0};
      vecs[5]  = '{1'b0, 32'h21, 2'd0, 1'b0, 32'h0,        32'h0000007F, 1'b0, 0};
      vecs[6]  = '{1'b0, 32'h22, 2'd0, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0, 0};
      vecs[7]  = '{1'b0, 32'h22, 2'd1, 1'b1, 32'h0,        32'h000080FF, 1'b0, 0};
      vecs[8]  = '{1'b0, 32'h22, 2'd1, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 2};
      vecs[9]  = '{1'b0, 32'h03, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 0};
      vecs[10] = '{1'b1, 32'h06, 2'd2, 1'b0, 32'h11223344, 32'h0,        1'b1, 0};
      vecs[11] = '{1'b0, 32'h00, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 0};
      vecs[12] = '{1'b0, 32'(4 * DEPTH), 2'd2, 1'b0, 32'h0, 32'h0,       1'b1, 0};
      vecs[13] = '{1'b1, 32'h22, 2'd1, 1'b0, 32'hCAFE1234, 32'h0,        1'b0, 0};
      vecs[14] = '{1'b0, 32'h20, 2'd2, 1'b0, 32'h0,        32'h12347F01, 1'b0, 0};
      vecs[15] = '{1'b0, 32'h23, 2'd0, 1'b1, 32'h0,        32'h00000012, 1'b0, 1};

      repeat (3) @(posedge CLK);
      #1;
      chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
      chk_bit("rst_rsp_err", rsp_err, 1'b0);
      chk_bit("rst_memread", memread, 1'b0);
      chk_bit("rst_memwrite", memwrite, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      @(negedge CLK);
      reset = 1'b1;
      #1;
      chk_bit("rst_release_ready", req_ready, 1'b1);

      for (int i = 0; i < 16; i++) begin
         model(vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].u, vecs[i].wd, m_rd, m_err);
         run_req(vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].u, vecs[i].wd,
                 vecs[i].exp_rd, vecs[i].exp_err, vecs[i].hold);
      end

      // Reset while a byte store sits in WAIT: the write must never happen.
      model(1'b1, 32'h30, 2'd2, 1'b0, 32'hA5A5C3C3, m_rd, m_err);
      run_req(1'b1, 32'h30, 2'd2, 1'b0, 32'hA5A5C3C3, 32'd0, 1'b0, 0);
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h31; req_size = 2'd0;
      req_unsigned = 1'b0; req_wdata = 32'h000000FF;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(posedge CLK); #1;
      reset = 1'b0;
      #1;
      chk_bit("midrst_rsp_valid", rsp_valid, 1'b0);
      chk_bit("midrst_rsp_err", rsp_err, 1'b0);
      chk_bit("midrst_memread", memread, 1'b0);
      chk_bit("midrst_memwrite", memwrite, 1'b0);
      chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
      chk("midrst_ram_addr", ram_addr, 32'd0);
      chk("midrst_write_data", write_data, 32'd0);
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge CLK); @(posedge CLK); #3;
      reset = 1'b1;
      #1;
      chk_bit("midrst_release_ready", req_ready, 1'b1);
      repeat (5) @(posedge CLK);
      #1;
      chk("midrst_no_read", 32'(rd_cnt - rd0), 32'd0);
      chk("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
      chk("midrst_ram_word", mem[12], 32'hA5A5C3C3);
      chk_bit("midrst_idle_ready", req_ready, 1'b1);

      for (int i = 0; i < 80; i++) begin
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         wd = $urandom;
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = 32'($urandom_range(0, 4 * DEPTH + 15));
         model(w, a, sz, u, wd, m_rd, m_err);
         run_req(w, a, sz, u, wd, m_rd, m_err, int'($urandom_range(0, 3)));
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i] !== ref_mem[i]) begin
            total++;
            bad++;
            $display("FAIL final_ram[%0d]: actual=%h expected=%h", i, mem[i], ref_mem[i]);
         end else begin
            total++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DEPTH, `ROM_COL_MAX, number of 32-bit words in the attached RAM; word indices >= DEPTH are out of range.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low (asserted at 0).
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  core consumes response.
REQ-013 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned, reserved size, or out-of-range access.
REQ-015 ram_addr  output  32  word index to RAM, req_addr[31:2] zero-extended.
REQ-016 memread  output  1  RAM read strobe; RAM returns read_data after the next rising edge.
REQ-017 memwrite  output  1  RAM write strobe.
REQ-018 write_data  output  32  full word to RAM.
REQ-019 read_data  input  32  RAM read result.

Function
REQ-020 FSM states: IDLE, RD, WAIT, WR, RESP. Exactly one active.
REQ-021 IDLE: req_ready=1; a request is accepted on an edge where req_valid=1; all req_* latched; req_ready=0 in every other state.
REQ-022 Error check at acceptance: size 11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=DEPTH -> RESP with rsp_err=1, no memread/memwrite ever asserted.
REQ-023 Legal load or sub-word store -> RD; legal word store -> WR.
REQ-024 RD: memread=1 one cycle, ram_addr=latched word index -> WAIT.
REQ-025 WAIT: read_data valid; load: select lane by addr[1:0] (little-endian), extend per size/req_unsigned, register into rsp_rdata -> RESP; sub-word store: merge req_wdata byte/half into the addressed lane of read_data, other lanes unchanged -> WR.
REQ-026 WR: memwrite=1 one cycle, write_data=merged word (or req_wdata for word store) -> RESP.
REQ-027 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on edge with rsp_ready=1 -> IDLE; hold indefinitely otherwise.
REQ-028 memread and memwrite never asserted together; both 0 outside RD/WR respectively; ram_addr and write_data hold latched values in all non-IDLE states.
REQ-029 Latency from accept edge to rsp_valid: load 3 cycles, word store 2, sub-word store 4, error 1.
REQ-030 No back-to-back acceptance: next request accepted no earlier than the cycle after RESP exits.
REQ-031 rsp_ready outside RESP is ignored.

Reset
REQ-032 reset=0 asynchronously forces IDLE; rsp_valid, rsp_err, memread, memwrite = 0; rsp_rdata, ram_addr, write_data and all latched request fields = 0.
REQ-033 Reset mid-operation abandons the transaction: no memread/memwrite after reset release until a new request is accepted; a write already committed at an edge before reset is not undone.
REQ-034 req_ready=1 in the first cycle after reset release.

Verification
REQ-035 Word store addr 0x10, data 0xDEADBEEF, then word load addr 0x10 -> memwrite with ram_addr=4; load rsp_rdata=0xDEADBEEF, rsp_err=0, latencies 2 and 3.
REQ-036 After REQ-035, byte store 0x5A at addr 0x12, then word load 0x10 -> RD then WR with write_data=0xDE5ABEEF; load returns 0xDE5ABEEF.
REQ-037 Loads from word 0x80FF7F01 at addr 0x20: signed byte @0x21 -> 0x0000007F; signed byte @0x22 -> 0xFFFFFFFF; unsigned half @0x22 -> 0x000080FF; signed half @0x22 -> 0xFFFF80FF.
REQ-038 Half load addr 0x3, word store addr 0x6, size 11, word load at byte address 4*DEPTH -> each rsp_err=1 one cycle after accept, rsp_rdata=0, memread=memwrite=0 throughout.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0; raise rsp_ready -> IDLE next edge.
REQ-040 Assert reset=0 during WAIT of a sub-word store -> outputs zero immediately, no memwrite after release, RAM word unchanged, req_ready=1 after release.
